// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared constants for the 8-bit CPU control path: opcode
//                values, ALU select codes, control FSM state encoding, IR
//                field bit positions and the branch offset helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

  // IR field bit positions
  localparam int c_op_msb   = 31;
  localparam int c_op_lsb   = 24;
  localparam int c_off_msb  = 23;
  localparam int c_off_lsb  = 16;
  localparam int c_dest_msb = 18;
  localparam int c_dest_lsb = 16;
  localparam int c_src1_msb = 10;
  localparam int c_src1_lsb = 8;
  localparam int c_src2_msb = 2;
  localparam int c_src2_lsb = 0;
  localparam int c_imm_msb  = 7;
  localparam int c_imm_lsb  = 0;

  // Opcodes
  localparam logic [7:0] c_op_loadi = 8'h00;
  localparam logic [7:0] c_op_mov   = 8'h01;
  localparam logic [7:0] c_op_add   = 8'h02;
  localparam logic [7:0] c_op_sub   = 8'h03;
  localparam logic [7:0] c_op_and   = 8'h04;
  localparam logic [7:0] c_op_or    = 8'h05;
  localparam logic [7:0] c_op_j     = 8'h06;
  localparam logic [7:0] c_op_beq   = 8'h07;
  localparam logic [7:0] c_op_bne   = 8'h08;
  localparam logic [7:0] c_op_sll   = 8'h09;
  localparam logic [7:0] c_op_srl   = 8'h0A;
  localparam logic [7:0] c_op_sra   = 8'h0B;
  localparam logic [7:0] c_op_ror   = 8'h0C;
  localparam logic [7:0] c_op_lwd   = 8'h0D;
  localparam logic [7:0] c_op_lwi   = 8'h0E;
  localparam logic [7:0] c_op_swd   = 8'h0F;
  localparam logic [7:0] c_op_swi   = 8'h10;

  // ALU select codes
  localparam logic [2:0] c_alu_fwd = 3'b000;
  localparam logic [2:0] c_alu_add = 3'b001;
  localparam logic [2:0] c_alu_and = 3'b010;
  localparam logic [2:0] c_alu_or  = 3'b011;
  localparam logic [2:0] c_alu_sll = 3'b100;
  localparam logic [2:0] c_alu_srl = 3'b101;
  localparam logic [2:0] c_alu_sra = 3'b110;
  localparam logic [2:0] c_alu_ror = 3'b111;

  // Control FSM state encoding
  localparam logic [1:0] c_st_fetch = 2'd0;
  localparam logic [1:0] c_st_exec  = 2'd1;
  localparam logic [1:0] c_st_mem   = 2'd2;

  // Word offset in the instruction becomes a signed byte displacement.
  function automatic logic [31:0] branch_disp(input logic [7:0] off);
    return {{22{off[7]}}, off, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_decoder
//  Description : Purely combinational instruction decoder. Turns the held
//                instruction register into ALU select, operand mux controls,
//                register-file addresses and instruction class flags.
//  Ports       : i_ir          instruction register
//                o_aluop       ALU operation select
//                o_imm_sel     ALU DATA2 from immediate
//                o_neg_sel     ALU DATA2 negated
//                o_imm         immediate byte
//                o_offset      jump/branch word offset
//                o_readreg1/2  register-file read addresses
//                o_writereg    register-file write address
//                o_is_*        instruction class flags
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_decoder (
  input  logic [31:0] i_ir,
  output logic [2:0]  o_aluop,
  output logic        o_imm_sel,
  output logic        o_neg_sel,
  output logic [7:0]  o_imm,
  output logic [7:0]  o_offset,
  output logic [2:0]  o_readreg1,
  output logic [2:0]  o_readreg2,
  output logic [2:0]  o_writereg,
  output logic        o_is_alu,
  output logic        o_is_jump,
  output logic        o_is_branch,
  output logic        o_is_bne,
  output logic        o_is_load,
  output logic        o_is_store,
  output logic        o_is_illegal
);
  import cpu_pkg::*;

  logic [7:0] w_op;
  logic [2:0] w_dest;
  logic [2:0] w_src1;
  logic       w_unused;

  assign w_op     = i_ir[c_op_msb:c_op_lsb];
  assign w_dest   = i_ir[c_dest_msb:c_dest_lsb];
  assign w_src1   = i_ir[c_src1_msb:c_src1_lsb];
  assign w_unused = ^i_ir[15:11];

  assign o_imm      = i_ir[c_imm_msb:c_imm_lsb];
  assign o_offset   = i_ir[c_off_msb:c_off_lsb];
  assign o_readreg2 = i_ir[c_src2_msb:c_src2_lsb];
  assign o_writereg = w_dest;
  // Stores read their data register through port 1.
  assign o_readreg1 = o_is_store ? w_dest : w_src1;

  always_comb begin
    o_aluop      = c_alu_fwd;
    o_imm_sel    = 1'b0;
    o_neg_sel    = 1'b0;
    o_is_alu     = 1'b0;
    o_is_jump    = 1'b0;
    o_is_branch  = 1'b0;
    o_is_bne     = 1'b0;
    o_is_load    = 1'b0;
    o_is_store   = 1'b0;
    o_is_illegal = 1'b0;
    case (w_op)
      c_op_loadi: begin o_is_alu = 1'b1; o_imm_sel = 1'b1; end
      c_op_mov:   o_is_alu = 1'b1;
      c_op_add:   begin o_is_alu = 1'b1; o_aluop = c_alu_add; end
      c_op_sub:   begin o_is_alu = 1'b1; o_aluop = c_alu_add; o_neg_sel = 1'b1; end
      c_op_and:   begin o_is_alu = 1'b1; o_aluop = c_alu_and; end
      c_op_or:    begin o_is_alu = 1'b1; o_aluop = c_alu_or; end
      c_op_j:     o_is_jump = 1'b1;
      c_op_beq:   begin o_is_branch = 1'b1; o_aluop = c_alu_add; o_neg_sel = 1'b1; end
      c_op_bne: begin
        o_is_branch = 1'b1;
        o_is_bne    = 1'b1;
        o_aluop     = c_alu_add;
        o_neg_sel   = 1'b1;
      end
      c_op_sll:   begin o_is_alu = 1'b1; o_aluop = c_alu_sll; o_imm_sel = 1'b1; end
      c_op_srl:   begin o_is_alu = 1'b1; o_aluop = c_alu_srl; o_imm_sel = 1'b1; end
      c_op_sra:   begin o_is_alu = 1'b1; o_aluop = c_alu_sra; o_imm_sel = 1'b1; end
      c_op_ror:   begin o_is_alu = 1'b1; o_aluop = c_alu_ror; o_imm_sel = 1'b1; end
      c_op_lwd:   o_is_load = 1'b1;
      c_op_lwi:   begin o_is_load = 1'b1; o_imm_sel = 1'b1; end
      c_op_swd:   o_is_store = 1'b1;
      c_op_swi:   begin o_is_store = 1'b1; o_imm_sel = 1'b1; end
      default:    o_is_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/cpu_control_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_control_fsm
//  Description : Multi-cycle FETCH/EXEC/MEM control unit for the 8-bit CPU.
//                Owns PC and IR, drives the ALU and register file, and
//                sequences data-memory accesses against BUSYWAIT.
//  Ports       : CLK, RESET (sync, active-high)
//                INSTRUCTION  instruction word at PC
//                ZERO         ALU zero flag (branches)
//                BUSYWAIT     data memory stall
//                PC           program counter
//                ALUOP, IMM_SEL, NEG_SEL, IMMEDIATE   ALU controls
//                READREG1/2, WRITEREG, WRITEENABLE, WB_SEL  register file
//                MEM_READ, MEM_WRITE  data memory strobes
//                ILLEGAL      one-cycle pulse on undefined opcode
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_fsm #(
  parameter logic [31:0] RESET_PC = 32'd0,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] INSTRUCTION,
  input  logic        ZERO,
  input  logic        BUSYWAIT,
  output logic [31:0] PC,
  output logic [2:0]  ALUOP,
  output logic        IMM_SEL,
  output logic        NEG_SEL,
  output logic [7:0]  IMMEDIATE,
  output logic [2:0]  READREG1,
  output logic [2:0]  READREG2,
  output logic [2:0]  WRITEREG,
  output logic        WRITEENABLE,
  output logic        WB_SEL,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic        ILLEGAL
);
  import cpu_pkg::*;

  logic [1:0]  r_state;
  logic [31:0] r_ir;
  logic [31:0] r_pc;

  logic [7:0]  w_offset;
  logic        w_is_alu;
  logic        w_is_jump;
  logic        w_is_branch;
  logic        w_is_bne;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_illegal;
  logic        w_taken;
  logic [31:0] w_pc_seq;
  logic [31:0] w_pc_target;
  logic [31:0] w_pc_exec;

  cpu_decoder u_decoder (
    .i_ir         (r_ir),
    .o_aluop      (ALUOP),
    .o_imm_sel    (IMM_SEL),
    .o_neg_sel    (NEG_SEL),
    .o_imm        (IMMEDIATE),
    .o_offset     (w_offset),
    .o_readreg1   (READREG1),
    .o_readreg2   (READREG2),
    .o_writereg   (WRITEREG),
    .o_is_alu     (w_is_alu),
    .o_is_jump    (w_is_jump),
    .o_is_branch  (w_is_branch),
    .o_is_bne     (w_is_bne),
    .o_is_load    (w_is_load),
    .o_is_store   (w_is_store),
    .o_is_illegal (w_is_illegal)
  );

  // PC arithmetic wraps modulo 2^32 by construction.
  assign w_pc_seq    = r_pc + 32'(PC_STEP);
  assign w_pc_target = w_pc_seq + branch_disp(w_offset);
  // ZERO comes from the ALU computing SRC1 - SRC2 during EXEC.
  assign w_taken     = w_is_branch & (w_is_bne ? ~ZERO : ZERO);
  assign w_pc_exec   = (w_is_jump | w_taken) ? w_pc_target : w_pc_seq;
  assign PC          = r_pc;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pc    <= RESET_PC;
      r_state <= c_st_fetch;
      r_ir    <= 32'd0;
    end else begin
      case (r_state)
        c_st_fetch: begin
          r_ir    <= INSTRUCTION;
          r_state <= c_st_exec;
        end
        c_st_exec: begin
          if (w_is_load | w_is_store) begin
            r_state <= c_st_mem;
          end else begin
            r_pc    <= w_pc_exec;
            r_state <= c_st_fetch;
          end
        end
        c_st_mem: begin
          if (!BUSYWAIT) begin
            r_pc    <= w_pc_seq;
            r_state <= c_st_fetch;
          end
        end
        default: r_state <= c_st_fetch;
      endcase
    end
  end

  // Strobe generation; RESET overrides combinationally so an access in
  // flight is dropped in the very cycle reset is asserted.
  always_comb begin
    WRITEENABLE = 1'b0;
    WB_SEL      = 1'b0;
    MEM_READ    = 1'b0;
    MEM_WRITE   = 1'b0;
    ILLEGAL     = 1'b0;
    case (r_state)
      c_st_exec: begin
        WRITEENABLE = w_is_alu;
        ILLEGAL     = w_is_illegal;
      end
      c_st_mem: begin
        MEM_READ    = w_is_load;
        MEM_WRITE   = w_is_store;
        WB_SEL      = w_is_load;
        // Load data is valid once memory drops BUSYWAIT.
        WRITEENABLE = w_is_load & ~BUSYWAIT;
      end
      default: ;
    endcase
    if (RESET) begin
      WRITEENABLE = 1'b0;
      MEM_READ    = 1'b0;
      MEM_WRITE   = 1'b0;
      ILLEGAL     = 1'b0;
    end
  end

endmodule
`default_nettype wire
